step3_normalize_pack: RTL and testbench

Output stage of the floating-point MAC pipeline. Each cycle it can receive one raw 48-bit unnormalized significand from the multiply/accumulate datapath, together with the exponent and sign that the step-2 delay line carried alongside it. It normalizes the significand with an iterative one-bit-per-cycle shifter, applies round-to-nearest-even, saturates or flushes the exponent, and packs an IEEE-754 single-precision word. A valid/ready handshake on both sides lets upstream stall while a multi-cycle normalization is in progress.

---
 rtl/step3_normalize_pack.sv | 146 ++++++++++++++
 tb/tb_step3_normalize_pack.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/step3_normalize_pack.sv
// step3_normalize_pack: output stage of the floating-point MAC pipeline.
// It takes a raw 48-bit significand with its exponent and sign, normalizes it
// one bit per cycle, rounds to nearest-even, saturates to infinity or flushes
// to signed zero, and packs an IEEE-754 single-precision word.
// The binary point of the incoming significand sits between bits 46 and 45.
`timescale 1ns/1ps
module step3_normalize_pack #(
  parameter int MAN_W   = 48,
  parameter int EXP_MAX = 255
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] in_man,
  input  logic [7:0]       in_ex,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [2:0]       out_flags
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

  logic [1:0]        state_q, state_d;
  logic [47:0]       m_q, m_d;
  logic signed [9:0] e_q, e_d;
  logic              sign_q, sign_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       result_q, result_d;
  logic [2:0]        flags_q, flags_d;

  logic              guardBit;
  logic              stickyAll;
  logic              roundUp;
  logic [23:0]       fracSum;
  logic signed [9:0] eRound;
  logic              inexact;

  // Round-to-nearest-even on the normalized significand; a carry out of the
  // 23-bit fraction leaves the fraction at zero and bumps the exponent.
  always_comb begin
    guardBit  = m_q[22];
    stickyAll = sticky_q | (|m_q[21:0]);
    roundUp   = guardBit & (stickyAll | m_q[23]);
    fracSum   = {1'b0, m_q[45:23]} + {23'b0, roundUp};
    eRound    = fracSum[23] ? (e_q + 10'sd1) : e_q;
    inexact   = guardBit | stickyAll;
  end

  // Next-state logic: capture in IDLE, shift one bit per cycle in NORM,
  // round and pack in ROUND, hold the result in DONE until it is taken.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d      = in_man;
          e_d      = {2'b00, in_ex};
          sign_d   = in_sign;
          sticky_d = 1'b0;
          if (in_man == '0) begin
            result_d = {in_sign, 31'b0};
            flags_d  = 3'b000;
            state_d  = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (m_q[47]) begin
          m_d      = {1'b0, m_q[47:1]};
          sticky_d = sticky_q | m_q[0];
          e_d      = e_q + 10'sd1;
          state_d  = ROUND;
        end else if (m_q[46]) begin
          state_d = ROUND;
        end else if (e_q <= 10'sd1) begin
          result_d = {sign_q, 31'b0};
          flags_d  = 3'b010;
          state_d  = DONE;
        end else begin
          m_d = {m_q[46:0], 1'b0};
          e_d = e_q - 10'sd1;
        end
      end
      ROUND: begin
        if (eRound >= EXP_MAX_S) begin
          result_d = {sign_q, 8'hFF, 23'b0};
          flags_d  = {1'b1, 1'b0, inexact};
        end else begin
          result_d = {sign_q, eRound[7:0], fracSum[22:0]};
          flags_d  = {1'b0, 1'b0, inexact};
        end
        e_d     = eRound;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any word in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_step3_normalize_pack.sv
// tb_step3_normalize_pack: directed vectors with hand-computed results for
// the normalize/round/pack stage, including latency, backpressure and reset.
`timescale 1ns/1ps
module tb_step3_normalize_pack;

  logic        clock;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_man;
  logic [7:0]  in_ex;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int checkCount;
  int errorCount;

  step3_normalize_pack dut (
    .clock      (clock),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_man     (in_man),
    .in_ex      (in_ex),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  // Free-running 100 MHz clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one word for a single accepting edge
  task automatic startWord(input logic [47:0] man, input logic [7:0] ex,
                           input logic sgn, input string tag);
    @(negedge clock);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_man   = man;
    in_ex    = ex;
    in_sign  = sgn;
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Count accept-to-valid latency; called at the first negedge after accept
  task automatic waitValid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
  endtask

  // Take the result with a one-cycle out_ready pulse and confirm IDLE
  task automatic releaseWord(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    checkOutput({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
  endtask

  // Full transaction: accept, wait, compare result/flags/latency, release
  task automatic applyStimulus(input string tag, input logic [47:0] man,
                               input logic [7:0] ex, input logic sgn,
                               input logic [31:0] expResult,
                               input logic [2:0] expFlags, input int expLat);
    int lat;
    startWord(man, ex, sgn, tag);
    waitValid(lat);
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, "_result"}, out_result, expResult);
    checkOutput({tag, "_flags"}, {29'b0, out_flags}, {29'b0, expFlags});
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    releaseWord(tag);
  endtask

  // Directed test sequence
  initial begin
    int  lat;
    logic sawValid;
    checkCount = 0;
    errorCount = 0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_man    = '0;
    in_ex     = '0;
    in_sign   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_result", out_result, 32'h0);
    checkOutput("rst_flags", {29'b0, out_flags}, 32'd0);
    resetn = 1'b1;

    applyStimulus("one_x_one", 48'h4000_0000_0000, 8'd127, 1'b0, 32'h3F80_0000, 3'b000, 3);
    applyStimulus("carry",     48'h8000_0000_0000, 8'd127, 1'b0, 32'h4000_0000, 3'b000, 3);
    applyStimulus("overflow",  48'h8000_0000_0000, 8'd254, 1'b0, 32'h7F80_0000, 3'b100, 3);
    applyStimulus("left6",     48'h0100_0000_0000, 8'd127, 1'b0, 32'h3C80_0000, 3'b000, 9);
    applyStimulus("tie_even",  48'h4000_0040_0000, 8'd127, 1'b0, 32'h3F80_0000, 3'b001, 3);
    applyStimulus("tie_odd",   48'h4000_00C0_0000, 8'd127, 1'b0, 32'h3F80_0002, 3'b001, 3);
    applyStimulus("rnd_carry", 48'h7FFF_FFC0_0000, 8'd127, 1'b0, 32'h4000_0000, 3'b001, 3);
    applyStimulus("zero_neg",  48'h0,              8'd127, 1'b1, 32'h8000_0000, 3'b000, 1);
    applyStimulus("uflow_j0",  48'h2000_0000_0000, 8'd1,   1'b0, 32'h0000_0000, 3'b010, 2);
    applyStimulus("uflow_j2",  48'h0800_0000_0000, 8'd3,   1'b1, 32'h8000_0000, 3'b010, 4);
    applyStimulus("worst",     48'h0000_0000_0001, 8'd127, 1'b0, 32'h2880_0000, 3'b000, 49);
    applyStimulus("sticky_lo", 48'h8000_0000_0001, 8'd127, 1'b0, 32'h4000_0000, 3'b001, 3);
    applyStimulus("sticky_up", 48'h8000_0080_0001, 8'd127, 1'b0, 32'h4000_0001, 3'b001, 3);

    // Backpressure: result and in_ready must hold while out_ready stays low
    startWord(48'h4000_0000_0000, 8'd127, 1'b1, "bp");
    waitValid(lat);
    checkOutput("bp_latency", 32'(lat), 32'd3);
    in_man   = 48'h8000_0000_0000;
    in_ex    = 8'd200;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput("bp_result", out_result, 32'hBF80_0000);
      checkOutput("bp_hold", {30'b0, out_valid, in_ready}, 32'd2);
    end
    in_valid = 1'b0;
    releaseWord("bp");

    // Reset during NORM drops the word without any out_valid pulse
    startWord(48'h0000_0000_0001, 8'd127, 1'b0, "rstmid");
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #2;
    checkOutput("rstmid_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstmid_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock);
    resetn = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("rstmid_novalid", {31'b0, sawValid}, 32'd0);
    checkOutput("rstmid_idle", {31'b0, in_ready}, 32'd1);
    applyStimulus("post_rst", 48'h4000_0000_0000, 8'd128, 1'b0, 32'h4000_0000, 3'b000, 3);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
